rf_tx_sample_packer: RTL

- Sits directly downstream of the RF Tx sample source.
- Captures strobed two-antenna IQ samples: four 12-bit lanes, one strobe per sample.
- Buffers them in a small FIFO and emits them as a framed, AXI-Stream-style 64-bit beat stream toward the DAC/transport path.
- Drives the ready back-pressure signal consumed by the sample source.
- Reports overflow, drop and frame statistics.

---
 rtl/rf_tx_sample_packer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rf_tx_sample_packer.sv
// rf_tx_sample_packer
//
// Captures strobed two-antenna IQ samples (four 12-bit lanes) from the RF Tx
// sample source and buffers them in a small FIFO. They leave as a framed
// 64-bit stream with a valid/ready handshake, one beat per sample.
//
// Ports:
//   I_clk, I_rst       sole clock; synchronous active-high reset
//   I_en               run enable; it gates only O_tReady
//   O_tReady           registered back-pressure toward the sample source
//   I_RF_txXEn         sample strobe, one cycle per sample
//   I_RF_tx{0,1}{Im,Re} 12-bit two's complement lanes
//   O_tValid/O_tData/O_tLast, I_mReady   output beat stream
//   O_ovf              sticky overflow flag
//   O_dropCnt          dropped samples, saturating
//   O_frameCnt         completed frames, wrapping
//   O_seqErr           sticky sequence error
//
// Optional feature: define RF_TX_SEQ_CHECK_EN to enable the ramp-sequence
// checker that drives O_seqErr. When the macro is undefined, O_seqErr is tied
// to 0 and no checker logic is built.

module rf_tx_sample_packer #(
  parameter int FRAME_LEN    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_en,
  output logic        O_tReady,
  input  logic        I_RF_txXEn,
  input  logic [11:0] I_RF_tx0Im,
  input  logic [11:0] I_RF_tx0Re,
  input  logic [11:0] I_RF_tx1Im,
  input  logic [11:0] I_RF_tx1Re,
  output logic        O_tValid,
  output logic [63:0] O_tData,
  output logic        O_tLast,
  input  logic        I_mReady,
  output logic        O_ovf,
  output logic [15:0] O_dropCnt,
  output logic [15:0] O_frameCnt,
  output logic        O_seqErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  // Lane packing, low lane first: {tx1Re, tx1Im, tx0Re, tx0Im}
  logic [47:0]   sample_in;
  logic [47:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  state_t        state_reg;
  state_t        state_next;
  logic [47:0]   data_reg;
  logic [15:0]   beat_reg;
  logic [15:0]   frame_cnt_reg;
  logic [15:0]   drop_cnt_reg;
  logic          ovf_reg;
  logic          tready_reg;

  logic          wr_en;
  logic          drop;
  logic          fifo_empty;
  logic          pop;
  logic          hs;
  logic          last_beat;

  assign sample_in  = {I_RF_tx1Re, I_RF_tx1Im, I_RF_tx0Re, I_RF_tx0Im};
  assign fifo_empty = (count_reg == '0);

  // Admission uses the count at the start of the cycle. A full FIFO drops the
  // sample even if a pop frees a slot in the same cycle.
  assign wr_en = I_RF_txXEn && (count_reg < CW'(FIFO_DEPTH));
  assign drop  = I_RF_txXEn && !wr_en;

  // Output stage: next state and pop decision
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    hs         = 1'b0;
    case (state_reg)
      S_EMPTY: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (I_mReady) begin
          hs = 1'b1;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next = S_EMPTY;
          end
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  assign count_next = count_reg + CW'(wr_en) - CW'(pop);
  assign last_beat  = (beat_reg == 16'(FRAME_LEN - 1));

  // Sample storage. It has no reset, and reads go only into data_reg.
  always_ff @(posedge I_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= sample_in;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= S_EMPTY;
      data_reg      <= '0;
      beat_reg      <= '0;
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
      ovf_reg       <= 1'b0;
      tready_reg    <= 1'b0;
    end else begin
      count_reg  <= count_next;
      state_reg  <= state_next;
      tready_reg <= I_en && (count_next <= CW'(FIFO_DEPTH - AFULL_MARGIN));

      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        data_reg   <= mem[rd_ptr_reg];
      end

      if (hs) begin
        if (last_beat) begin
          beat_reg      <= '0;
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end else begin
          beat_reg <= beat_reg + 16'd1;
        end
      end

      if (drop) begin
        ovf_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end
    end
  end

  // Sign-extend each 12-bit lane into its 16-bit slot
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sext
      assign O_tData[gi*16 +: 16] = {{4{data_reg[gi*12 + 11]}}, data_reg[gi*12 +: 12]};
    end
  endgenerate

  assign O_tValid   = (state_reg == S_FULL);
  assign O_tLast    = (state_reg == S_FULL) && last_beat;
  assign O_tReady   = tready_reg;
  assign O_ovf      = ovf_reg;
  assign O_dropCnt  = drop_cnt_reg;
  assign O_frameCnt = frame_cnt_reg;

`ifdef RF_TX_SEQ_CHECK_EN
  // Each accepted sample must equal the previously accepted one plus
  // {+4, +3, +2, +1} per lane, modulo 4096. A drop breaks the chain, so the
  // next accepted sample only becomes the new reference.
  logic [47:0] ref_reg;
  logic        have_ref_reg;
  logic        seq_err_reg;
  logic [3:0]  lane_bad;

  for (gi = 0; gi < 4; gi++) begin : g_seq
    assign lane_bad[gi] = (sample_in[gi*12 +: 12] != (ref_reg[gi*12 +: 12] + 12'(gi + 1)));
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      ref_reg      <= '0;
      have_ref_reg <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else if (wr_en) begin
      ref_reg      <= sample_in;
      have_ref_reg <= 1'b1;
      if (have_ref_reg && (|lane_bad)) begin
        seq_err_reg <= 1'b1;
      end
    end else if (drop) begin
      have_ref_reg <= 1'b0;
    end
  end

  assign O_seqErr = seq_err_reg;
`else
  assign O_seqErr = 1'b0;
`endif

endmodule
